// File: rtl/uart_secded_pkg.sv
// Shared types and code-layout constants for the UART SEC-DED link.
// Hamming(12,8) plus an overall parity bit in c[0]; 13-bit codeword.
package uart_secded_pkg;

  localparam int CODE_SIZE = 13;

  // Hamming positions carrying data bits d0..d7, and the check-bit positions.
  localparam int DPOS [0:7] = '{3, 5, 6, 7, 9, 10, 11, 12};
  localparam int PPOS [0:3] = '{1, 2, 4, 8};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    DECODE = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_secded_if.sv
// Bundle between the UART RX engine and its consumer: serial line in, decoded byte out.
// data_valid is a one-cycle strobe with no ready/backpressure; real_output is held
// between strobes, and error_corrected/double_error are meaningful only while data_valid is 1.
interface uart_rx_secded_if #(
  parameter int DATA_SIZE = 8
);

  logic                          baud_en;
  logic                          rx;
  logic [DATA_SIZE-1:0]          real_output;
  logic                          data_valid;
  logic                          error_corrected;
  logic                          double_error;
  logic [2:0]                    RX_status_register;
  uart_secded_pkg::rx_state_t    dbg_state;

  modport slave (
    input  baud_en, rx,
    output real_output, data_valid, error_corrected, double_error,
           RX_status_register, dbg_state
  );

  modport master (
    output baud_en, rx,
    input  real_output, data_valid, error_corrected, double_error,
           RX_status_register, dbg_state
  );

endinterface

// File: rtl/uart_rx_secded_decode.sv
// Combinational SEC-DED decoder for a 13-bit Hamming(12,8)+overall-parity codeword.
// Shared with the transmit side's encoder self-check.
module secded_decode_13_8
  import uart_secded_pkg::*;
(
  input  logic [CODE_SIZE-1:0] i_code,
  output logic [7:0]           o_data,
  output logic                 o_corrected,
  output logic                 o_double_err
);

  logic [3:0]           w_syn;
  logic                 w_par;
  logic [CODE_SIZE-1:0] w_fixed;

  always_comb begin
    w_syn = '0;
    // Syndrome bit k covers every position whose index has check-bit PPOS[k] set.
    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < CODE_SIZE; i++) begin
        if ((i & PPOS[k]) != 0) begin
          w_syn[k] = w_syn[k] ^ i_code[i];
        end
      end
    end

    w_par = ^i_code;

    // Only a parity-odd word is correctable; a syndrome above 12 matches nothing.
    for (int i = 0; i < CODE_SIZE; i++) begin
      w_fixed[i] = i_code[i] ^ (w_par && (w_syn == 4'(i)));
    end

    o_corrected  = w_par && (w_syn <= 4'd12);
    o_double_err = (w_par && (w_syn > 4'd12)) || (!w_par && (w_syn != 4'd0));

    for (int j = 0; j < 8; j++) begin
      o_data[j] = w_fixed[DPOS[j]];
    end
  end

endmodule

// File: rtl/uart_rx_secded.sv
// UART receive engine: oversamples rx on baud_en, deserialises a SEC-DED codeword, decodes it.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit sample point.
module uart_rx_secded
  import uart_secded_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int SAMPLE    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_rx_secded_if.slave bus
);

  localparam int TW = $clog2(SAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  // Voting needs the sample after mid, so every decision lands one tick later.
  localparam logic [TW-1:0] T_START = TW'(SAMPLE / 2);
`else
  localparam logic [TW-1:0] T_START = TW'(SAMPLE / 2 - 1);
`endif

  rx_state_t            r_state, w_state_nx;
  logic [TW-1:0]        r_tcnt, w_tcnt_nx;
  logic [3:0]           r_bcnt, w_bcnt_nx;
  logic [CODE_SIZE-1:0] r_code;
  logic [DATA_SIZE-1:0] r_real_output;
  logic                 r_data_valid;
  logic                 r_err_corr;
  logic                 r_dbl_err;
  logic                 r_frame_err;
  logic                 r_last_err;

  logic                 w_bit;
  logic                 w_shift;
  logic                 w_good_stop;
  logic                 w_bad_stop;
  logic [7:0]           w_dec_data;
  logic                 w_dec_corr;
  logic                 w_dec_dbl;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hist <= 2'b11;
    end else if (bus.baud_en) begin
      r_hist <= {r_hist[0], bus.rx};
    end
  end

  assign w_bit = majority3(bus.rx, r_hist[0], r_hist[1]);
`else
  assign w_bit = bus.rx;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_tcnt_nx   = r_tcnt;
    w_bcnt_nx   = r_bcnt;
    w_shift     = 1'b0;
    w_good_stop = 1'b0;
    w_bad_stop  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.baud_en && !bus.rx) begin
          w_state_nx = START;
          w_tcnt_nx  = '0;
        end
      end

      START: begin
        if (bus.baud_en) begin
          if (r_tcnt == T_START) begin
            w_tcnt_nx = '0;
            w_bcnt_nx = '0;
            w_state_nx = w_bit ? IDLE : DATA;
          end else begin
            w_tcnt_nx = r_tcnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (bus.baud_en) begin
          if (r_tcnt == T_LAST) begin
            w_shift   = 1'b1;
            w_tcnt_nx = '0;
            if (r_bcnt == 4'd12) begin
              w_state_nx = STOP;
            end else begin
              w_bcnt_nx = r_bcnt + 4'd1;
            end
          end else begin
            w_tcnt_nx = r_tcnt + TW'(1);
          end
        end
      end

      STOP: begin
        if (bus.baud_en) begin
          if (r_tcnt == T_LAST) begin
            w_tcnt_nx = '0;
            if (w_bit) begin
              w_good_stop = 1'b1;
              w_state_nx  = DECODE;
            end else begin
              w_bad_stop = 1'b1;
              w_state_nx = IDLE;
            end
          end else begin
            w_tcnt_nx = r_tcnt + TW'(1);
          end
        end
      end

      DECODE: begin
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  secded_decode_13_8 u_decode (
    .i_code       (r_code),
    .o_data       (w_dec_data),
    .o_corrected  (w_dec_corr),
    .o_double_err (w_dec_dbl)
  );

  // Results are registered on the stop-sample edge, so the strobe coincides with DECODE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tcnt        <= '0;
      r_bcnt        <= '0;
      r_code        <= '0;
      r_real_output <= '0;
      r_data_valid  <= 1'b0;
      r_err_corr    <= 1'b0;
      r_dbl_err     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_last_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_tcnt       <= w_tcnt_nx;
      r_bcnt       <= w_bcnt_nx;
      r_data_valid <= w_good_stop;
      r_err_corr   <= w_good_stop & w_dec_corr;
      r_dbl_err    <= w_good_stop & w_dec_dbl;
      if (w_shift) begin
        r_code <= {w_bit, r_code[CODE_SIZE-1:1]};
      end
      if (w_good_stop) begin
        r_real_output <= DATA_SIZE'(w_dec_data);
        r_last_err    <= w_dec_corr | w_dec_dbl;
        r_frame_err   <= 1'b0;
      end else if (w_bad_stop) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.real_output        = r_real_output;
  assign bus.data_valid         = r_data_valid;
  assign bus.error_corrected    = r_err_corr;
  assign bus.double_error       = r_dbl_err;
  assign bus.RX_status_register = {r_frame_err, r_last_err, r_state != IDLE};
  assign bus.dbg_state          = r_state;

endmodule

// File: doc/uart_rx_secded.md
Name: uart_rx_secded

Overview:
- Receive stage of the UART SEC-DED link. It consumes the serial line driven by the transmit path's `tx`.
- It oversamples `rx` using the shared `baud_en` tick, deserialises one 13-bit Hamming(12,8)+overall-parity codeword per frame, and corrects single errors.
- It flags double errors and framing errors, and presents the 8-bit byte with a one-cycle valid strobe.
- It sits inside `uart_top` as the RX engine, producing `real_output`, `RX_status_register`, `error_corrected` and `double_error`.

Parameters:
- DATA_SIZE, 8, payload width; only 8 is supported. A localparam sets CODE_SIZE = 13.
- SAMPLE, 32, `baud_en` ticks per bit period; must be even and at least 8.

Ports:
- clk  in  1  system clock, single domain
- reset_n  in  1  synchronous, active-low reset
- baud_en  in  1  one-clk oversample tick, SAMPLE ticks per bit
- rx  in  1  serial input; idle high
- real_output  out  8  decoded/corrected byte, held until next valid frame
- data_valid  out  1  one-clk pulse when real_output is updated
- error_corrected  out  1  qualified by data_valid; single error fixed
- double_error  out  1  qualified by data_valid; uncorrectable error
- RX_status_register  out  3  {frame_err_sticky, last_err, busy}

Behaviour:
- Frame format: start(0), c[0]..c[12] LSB first, stop(1).
  - c[0] = overall even parity over c[1..12].
  - c[i], i = 1..12, is Hamming position i.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-frame abandons the frame and issues no data_valid.
- State machine. All counting advances only on `baud_en`; `tcnt` is the tick counter, `bcnt` the bit counter.
  - IDLE: on a tick with rx==0 → START, tcnt=0.
  - START: at tcnt==SAMPLE/2-1, rx==0 → DATA with tcnt=0, bcnt=0; rx==1 is a glitch → IDLE, no flags.
  - DATA: at tcnt==SAMPLE-1, sample rx into c[bcnt] and clear tcnt. After bcnt==12 → STOP.
  - STOP: at tcnt==SAMPLE-1, rx==1 → DECODE. rx==0 sets frame_err_sticky and → IDLE with no data_valid.
  - DECODE: one clk, not tick-gated. Registers outputs, pulses data_valid, → IDLE.
- Latency: data_valid is high on the clk after the stop-bit sample edge.
- Decode:
  - Syndrome s[3:0] = XOR of i over all i with c[i]==1. P = XOR of c[0..12].
  - s==0, P==0: clean.
  - P==1, s==0: error in c[0]; data unchanged; error_corrected=1.
  - P==1, 1≤s≤12: flip c[s]; error_corrected=1.
  - P==1, s>12: treat as double_error.
  - P==0, s!=0: double_error=1; real_output = uncorrected data bits.
  - error_corrected and double_error are never both 1.
  - Outside the data_valid cycle both flags read 0.
- Status register:
  - busy = state!=IDLE.
  - last_err = error_corrected|double_error of the last valid frame, held.
  - frame_err_sticky clears on the next good stop bit.
- Simultaneous events: a start edge during the DECODE cycle is sampled on the next tick in IDLE. No frame is lost because DECODE is shorter than one tick.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value (including start and stop) is the 2-of-3 majority of samples at ticks mid-1, mid and mid+1, where mid = SAMPLE/2-1 for start and SAMPLE-1 for other bits. A single-tick noise sample does not change the decoded bit.
- Undefined: single sample at the tick point. No extra registers.

Decomposition:
- Package `uart_secded_pkg` holds:
  - the state enum {IDLE, START, DATA, STOP, DECODE};
  - CODE_SIZE = 13;
  - localparam data-position table DPOS[0:7] = {3, 5, 6, 7, 9, 10, 11, 12};
  - the parity-position constants.
- Sub-module `secded_decode_13_8`: purely combinational. Input c[12:0]; outputs data[7:0], corrected, double_err. It is reusable by the encoder's self-check.

Test Plan:
- Bench drives rx bit-accurately with `baud_en` every clk (SAMPLE=32).
- Clean frame, 0xA5 → one data_valid pulse; real_output=0xA5; both flags 0; status=3'b000 after the frame.
- Frame for 0x3C with c[5] inverted → real_output=0x3C; error_corrected=1; double_error=0; last_err=1.
- Frame for 0x00 with only c[0] inverted → real_output=0x00; error_corrected=1.
- Frame for 0xFF with c[3] and c[6] inverted → double_error=1; error_corrected=0; real_output = raw bits (0xFF with d0 and d2 cleared = 0xFA).
- Valid 0x55 frame with stop bit 0 → no data_valid; frame_err_sticky=1. Next good 0x55 frame clears it. Separately, rx low for 8 ticks then high → returns to IDLE with no flags.
- reset_n low for one clk at bit 6 of a 0x81 frame → all outputs 0, no data_valid. A following 0x81 frame decodes correctly.
